// File: rtl/full_adder_pkg.sv
// Shared constants, result type and packing helper for the ripple-carry full adder.
// Optional signed-overflow output is enabled with the FULL_ADDER_OVF_EN macro.
package full_adder_pkg;

    localparam int unsigned FA_WIDTH_DEFAULT = 1;
    localparam int unsigned FA_WIDTH_MAX     = 64;

    typedef struct packed {
        logic                    carry;
        logic [FA_WIDTH_MAX-1:0] sum;
    } fa_result_t;

    function automatic fa_result_t fa_pack(input logic carry, input logic [FA_WIDTH_MAX-1:0] sum);
        fa_result_t res;
        res.carry = carry;
        res.sum   = sum;
        return res;
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; the slave modport is the adder side.
// The ovf_r signal exists only when FULL_ADDER_OVF_EN is defined.
interface full_adder_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic [WIDTH-1:0] S_r;
    logic             Co_r;
    logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_r;

    modport master (
        output A, B, Ci, in_valid,
        input  S, Co, S_r, Co_r, out_valid, ovf_r
    );

    modport slave (
        input  A, B, Ci, in_valid,
        output S, Co, S_r, Co_r, out_valid, ovf_r
    );
`else
    modport master (
        output A, B, Ci, in_valid,
        input  S, Co, S_r, Co_r, out_valid
    );

    modport slave (
        input  A, B, Ci, in_valid,
        output S, Co, S_r, Co_r, out_valid
    );
`endif
endinterface

// File: rtl/fa_cell.sv
// One-bit full adder, the ripple stage of full_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational and registered results.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow flag ovf_r.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    full_adder_if.slave bus
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    fa_result_t       w_res;

    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_valid;

    assign w_carry[0] = bus.Ci;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        fa_cell u_cell (
            .a  (bus.A[gi]),
            .b  (bus.B[gi]),
            .ci (w_carry[gi]),
            .s  (w_sum[gi]),
            .co (w_carry[gi+1])
        );
    end

    assign w_res = fa_pack(w_carry[WIDTH], FA_WIDTH_MAX'(w_sum));

    // Upper bits of the shared result type are zero padding at narrow widths.
    if (WIDTH < FA_WIDTH_MAX) begin : g_pad
        logic w_unused_hi;
        assign w_unused_hi = ^w_res.sum[FA_WIDTH_MAX-1:WIDTH];
    end

    assign bus.S  = w_res.sum[WIDTH-1:0];
    assign bus.Co = w_res.carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum <= w_res.sum[WIDTH-1:0];
                r_co  <= w_res.carry;
            end
        end
    end

    assign bus.S_r       = r_sum;
    assign bus.Co_r      = r_co;
    assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Like-signed operands producing an opposite-signed sum.
    assign w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf_r = r_ovf;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Overflow-flag checks are compiled in only with FULL_ADDER_OVF_EN.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg8(input string tag, input logic [7:0] s, input logic co,
                            input logic ov);
        check({tag, "_S_r"}, bus8.S_r, s);
        check({tag, "_Co_r"}, bus8.Co_r, co);
        check({tag, "_out_valid"}, bus8.out_valid, ov);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic v);
        bus8.A = a;
        bus8.B = b;
        bus8.Ci = ci;
        bus8.in_valid = v;
    endtask

    initial begin
        logic [1:0] exp1 [8];
        logic [8:0] exp9;

        exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst = 1'b1;
        bus1.A = 1'b0;
        bus1.B = 1'b0;
        bus1.Ci = 1'b0;
        bus1.in_valid = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b1);

        // Reset state, with in_valid asserted to show reset wins
        step();
        step();
        chk_reg8("rst", 8'h00, 1'b0, 1'b0);
        check("rst_w1_S_r", bus1.S_r, 1'b0);
        check("rst_w1_out_valid", bus1.out_valid, 1'b0);
`ifdef FULL_ADDER_OVF_EN
        check("rst_ovf_r", bus8.ovf_r, 1'b0);
`endif
        rst = 1'b0;
        bus8.in_valid = 1'b0;

        // WIDTH=1 truth table, each vector held 10 ns
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            bus1.A = v[2];
            bus1.B = v[1];
            bus1.Ci = v[0];
            #1;
            check($sformatf("w1_S_%0d", i), bus1.S, exp1[i][0]);
            check($sformatf("w1_Co_%0d", i), bus1.Co, exp1[i][1]);
            #9;
        end

        // WIDTH=1 registered path
        bus1.A = 1'b1;
        bus1.B = 1'b1;
        bus1.Ci = 1'b1;
        bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        check("w1_S_r", bus1.S_r, 1'b1);
        check("w1_Co_r", bus1.Co_r, 1'b1);
        check("w1_out_valid", bus1.out_valid, 1'b1);

        // 0xFF + 0x01: comb result immediate, registered one cycle later
        drive8(8'hFF, 8'h01, 1'b0, 1'b1);
        #1;
        check("ff01_S", bus8.S, 8'h00);
        check("ff01_Co", bus8.Co, 1'b1);
        step();
        bus8.in_valid = 1'b0;
        chk_reg8("ff01", 8'h00, 1'b1, 1'b1);
        step();
        chk_reg8("ff01_after", 8'h00, 1'b1, 1'b0);

        // Three back-to-back captures
        drive8(8'h10, 8'h20, 1'b0, 1'b1);
        step();
        drive8(8'hF0, 8'h0F, 1'b1, 1'b1);
        chk_reg8("b2b0", 8'h30, 1'b0, 1'b1);
`ifdef FULL_ADDER_OVF_EN
        check("b2b0_ovf_r", bus8.ovf_r, 1'b0);
`endif
        step();
        drive8(8'h80, 8'h80, 1'b0, 1'b1);
        chk_reg8("b2b1", 8'h00, 1'b1, 1'b1);
        step();
        bus8.in_valid = 1'b0;
        chk_reg8("b2b2", 8'h00, 1'b1, 1'b1);
`ifdef FULL_ADDER_OVF_EN
        check("b2b2_ovf_r", bus8.ovf_r, 1'b1);
`endif
        step();
        check("b2b_idle_out_valid", bus8.out_valid, 1'b0);

        // Signed overflow boundary: 0x7F+0x01 overflows, 0xFF+0x01 does not
        drive8(8'h7F, 8'h01, 1'b0, 1'b1);
        #1;
        check("7f01_S", bus8.S, 8'h80);
        step();
        drive8(8'hFF, 8'h01, 1'b0, 1'b1);
        chk_reg8("7f01", 8'h80, 1'b0, 1'b1);
`ifdef FULL_ADDER_OVF_EN
        check("7f01_ovf_r", bus8.ovf_r, 1'b1);
`endif
        step();
        bus8.in_valid = 1'b0;
        chk_reg8("ff01b", 8'h00, 1'b1, 1'b1);
`ifdef FULL_ADDER_OVF_EN
        check("ff01b_ovf_r", bus8.ovf_r, 1'b0);
`endif

        // Hold: one capture, then 5 idle cycles with random operands
        drive8(8'h12, 8'h34, 1'b1, 1'b1);
        step();
        bus8.in_valid = 1'b0;
        chk_reg8("hold_cap", 8'h47, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus8.A = 8'($urandom);
            bus8.B = 8'($urandom);
            exp9 = {1'b0, bus8.A} + {1'b0, bus8.B} + 9'(bus8.Ci);
            #1;
            check($sformatf("hold_S_%0d", i), {bus8.Co, bus8.S}, exp9);
            step();
            chk_reg8($sformatf("hold_%0d", i), 8'h47, 1'b0, 1'b0);
        end

        // Reset coinciding with a capture drops it; comb path unaffected
        drive8(8'h55, 8'h55, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("rst55_S_pre", bus8.S, 8'hAA);
        check("rst55_Co_pre", bus8.Co, 1'b0);
        step();
        chk_reg8("rst55", 8'h00, 1'b0, 1'b0);
        check("rst55_S_post", bus8.S, 8'hAA);
        rst = 1'b0;
        bus8.in_valid = 1'b0;

        // Wrap-around extremes
        drive8(8'hFF, 8'hFF, 1'b1, 1'b0);
        #1;
        check("wrap_ones_S", bus8.S, 8'hFF);
        check("wrap_ones_Co", bus8.Co, 1'b1);
        drive8(8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        check("wrap_zero_S", bus8.S, 8'h00);
        check("wrap_zero_Co", bus8.Co, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all registered outputs.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: A  input  WIDTH  addend A, unsigned.
REQ-006 Port: B  input  WIDTH  addend B, unsigned.
REQ-007 Port: Ci  input  1  carry-in.
REQ-008 Port: in_valid  input  1  qualifies A/B/Ci for capture.
REQ-009 Port: S  output  WIDTH  combinational sum.
REQ-010 Port: Co  output  1  combinational carry-out.
REQ-011 Port: S_r  output  WIDTH  registered sum.
REQ-012 Port: Co_r  output  1  registered carry-out.
REQ-013 Port: out_valid  output  1  S_r/Co_r hold a newly captured result.
REQ-014 Port (FULL_ADDER_OVF_EN only): ovf_r  output  1  registered signed-overflow flag.

Function
REQ-015 {Co,S} SHALL equal A + B + Ci, computed at WIDTH+1 bits, with no truncation other than the split into Co and S.
REQ-016 S and Co SHALL be purely combinational, settle in the same time step as any input change, and be independent of clk and rst.
REQ-017 At WIDTH=1: S = A xor B xor Ci; Co = (A and B) or (Ci and (A xor B)).
REQ-018 On a rising clk edge with rst=0 and in_valid=1, S_r/Co_r SHALL load the current S/Co and out_valid SHALL be 1 on the next cycle; latency is exactly 1 cycle.
REQ-019 On a rising clk edge with rst=0 and in_valid=0, S_r/Co_r (and ovf_r) SHALL hold their values and out_valid SHALL be 0 on the next cycle.
REQ-020 Back-to-back in_valid=1 SHALL give one result per cycle, with no bubbles.
REQ-021 Wrap-around: all-ones + all-ones + 1 gives S = all-ones and Co = 1; all-zeros + all-zeros + 0 gives S = 0 and Co = 0.
REQ-022 ovf_r SHALL capture (A[MSB]==B[MSB]) and (S[MSB]!=A[MSB]) on the same edges that load S_r.

Reset
REQ-023 When rst=1 on a rising edge, S_r, Co_r, out_valid and ovf_r SHALL all be 0 on the next cycle, whatever the state of in_valid.
REQ-024 rst SHALL take priority over in_valid; a capture that coincides with reset is dropped.
REQ-025 The combinational S/Co SHALL be unaffected by rst.

Configuration
REQ-026 Macro FULL_ADDER_OVF_EN defined: the ovf_r port and its register SHALL be present and behave as in REQ-022.
REQ-027 Macro FULL_ADDER_OVF_EN undefined: the ovf_r port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 Package full_adder_pkg SHALL hold the default width constant (FA_WIDTH_DEFAULT = 1) and a result typedef of {carry, sum[WIDTH]}.
REQ-029 Sub-module fa_cell (1-bit full adder: a, b, ci -> s, co) SHALL be instantiated WIDTH times as a ripple-carry chain.
REQ-030 Stage i carry-out SHALL feed stage i+1 carry-in; Ci drives stage 0 and the stage WIDTH-1 carry-out drives Co.

Verification
REQ-031 WIDTH=1: apply all 8 A/B/Ci combinations, each held 10 ns -> S/Co = 000:0/0, 001:1/0, 010:1/0, 011:0/1, 100:1/0, 101:0/1, 110:0/1, 111:1/1.
REQ-032 WIDTH=8: A=0xFF, B=0x01, Ci=0, in_valid=1 for one edge -> S=0x00 and Co=1 immediately; S_r=0x00, Co_r=1, out_valid=1 one cycle later, then out_valid=0.
REQ-033 WIDTH=8: in_valid=1 for 3 consecutive cycles with (0x10+0x20+0), (0xF0+0x0F+1), (0x80+0x80+0) -> S_r/Co_r = 0x30/0, 0x00/1, 0x00/1 on consecutive cycles.
REQ-034 Reset mid-operation: rst=1 and in_valid=1 on the same edge with A=0x55, B=0x55 -> S_r=0, Co_r=0, out_valid=0 next cycle; S=0xAA throughout.
REQ-035 FULL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01+0 -> ovf_r=1; 0xFF+0x01+0 -> ovf_r=0.
REQ-036 Hold behaviour: after one capture, set in_valid=0 for 5 cycles while randomising A/B -> S_r/Co_r stay unchanged and out_valid=0.
